sys_cmd_master: RTL

SYS_CMD_MASTER -- requirements
Module: sys_cmd_master

---
 rtl/sys_cmd_master_if.sv | 46 ++++
 rtl/sys_cmd_master.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/sys_cmd_master_if.sv
// Request, transmit, receive and response signals of the command master.
//
// Handshake rules: a request transfers on a rising edge where REQ_VLD and
// REQ_RDY are both 1. A transmit byte transfers on a rising edge where
// TX_D_VLD is 1 and TX_BUSY is 0. While TX_D_VLD is 1, TX_P_DATA is held
// until the transfer. RX_D_VLD and RSP_VLD are single-cycle pulses with no
// back-pressure.
interface sys_cmd_master_if #(
  parameter int data_width    = 8,
  parameter int address_width = 4,
  parameter int fun_width     = 4
);
  logic                     REQ_VLD;
  logic [1:0]               REQ_TYPE;
  logic [address_width-1:0] REQ_ADDR;
  logic [data_width-1:0]    REQ_DATA_A;
  logic [data_width-1:0]    REQ_DATA_B;
  logic [fun_width-1:0]     REQ_FUN;
  logic                     REQ_RDY;
  logic [data_width-1:0]    TX_P_DATA;
  logic                     TX_D_VLD;
  logic                     TX_BUSY;
  logic [data_width-1:0]    RX_P_DATA;
  logic                     RX_D_VLD;
  logic [2*data_width-1:0]  RSP_DATA;
  logic                     RSP_VLD;
  logic                     RSP_ERR;

  modport master (
    input  REQ_VLD, REQ_TYPE, REQ_ADDR, REQ_DATA_A, REQ_DATA_B, REQ_FUN,
    output REQ_RDY,
    output TX_P_DATA, TX_D_VLD,
    input  TX_BUSY,
    input  RX_P_DATA, RX_D_VLD,
    output RSP_DATA, RSP_VLD, RSP_ERR
  );

  modport slave (
    output REQ_VLD, REQ_TYPE, REQ_ADDR, REQ_DATA_A, REQ_DATA_B, REQ_FUN,
    input  REQ_RDY,
    input  TX_P_DATA, TX_D_VLD,
    output TX_BUSY,
    output RX_P_DATA, RX_D_VLD,
    input  RSP_DATA, RSP_VLD, RSP_ERR
  );
endinterface

// File: rtl/sys_cmd_master.sv
// Command master: turns one request into a byte frame on the TX side, then
// collects zero, one or two response bytes (with a timeout) and reports the
// result as a one-cycle RSP_VLD pulse.
module sys_cmd_master #(
  parameter int data_width    = 8,
  parameter int address_width = 4,
  parameter int fun_width     = 4,
  parameter int timeout_cyc   = 1024
) (
  input  logic             CLK,
  input  logic             RST,
  sys_cmd_master_if.master bus,
  output logic [2:0]       dbg_state
);

  localparam int cnt_w = (timeout_cyc > 2) ? $clog2(timeout_cyc) : 1;
  localparam logic [cnt_w-1:0] cnt_last = cnt_w'(timeout_cyc - 1);

  localparam logic [1:0] typ_wr  = 2'd0;
  localparam logic [1:0] typ_rd  = 2'd1;
  localparam logic [1:0] typ_alu = 2'd2;
  localparam logic [1:0] typ_fun = 2'd3;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SEND      = 3'd1,
    WAIT_RSP1 = 3'd2,
    WAIT_RSP2 = 3'd3,
    DONE      = 3'd4
  } state_t;

  state_t                   state_q, state_d;
  logic [1:0]               typ_q, typ_d;
  logic [address_width-1:0] addr_q, addr_d;
  logic [data_width-1:0]    a_q, a_d;
  logic [data_width-1:0]    b_q, b_d;
  logic [fun_width-1:0]     fun_q, fun_d;
  logic [1:0]               idx_q, idx_d;
  logic                     tx_vld_q, tx_vld_d;
  logic [data_width-1:0]    tx_data_q, tx_data_d;
  logic [cnt_w-1:0]         cnt_q, cnt_d;
  logic [2*data_width-1:0]  rx_buf_q, rx_buf_d;
  logic [2*data_width-1:0]  rsp_data_q, rsp_data_d;
  logic                     rsp_err_q, rsp_err_d;
  logic                     timed_out;

  // Byte idx of the frame for request type typ; narrow fields zero-extended.
  function automatic logic [data_width-1:0] frame_byte(
    input logic [1:0]               typ,
    input logic [1:0]               idx,
    input logic [address_width-1:0] addr,
    input logic [data_width-1:0]    a,
    input logic [data_width-1:0]    b,
    input logic [fun_width-1:0]     fun
  );
    logic [data_width-1:0] addr_x;
    logic [data_width-1:0] fun_x;
    logic [data_width-1:0] r;
    addr_x = data_width'(addr);
    fun_x  = data_width'(fun);
    r      = '0;
    case (idx)
      2'd0: begin
        case (typ)
          typ_wr:  r = data_width'(8'hAA);
          typ_rd:  r = data_width'(8'hBB);
          typ_alu: r = data_width'(8'hCC);
          default: r = data_width'(8'hDD);
        endcase
      end
      2'd1:    r = (typ == typ_alu) ? a : ((typ == typ_fun) ? fun_x : addr_x);
      2'd2:    r = (typ == typ_wr) ? a : b;
      default: r = fun_x;
    endcase
    return r;
  endfunction

  // Index of the final byte of each frame type.
  function automatic logic [1:0] last_idx(input logic [1:0] typ);
    case (typ)
      typ_wr:  return 2'd2;
      typ_alu: return 2'd3;
      default: return 2'd1;
    endcase
  endfunction

  // Next-state, frame sequencing, response collection and timeout.
  always_comb begin
    state_d    = state_q;
    typ_d      = typ_q;
    addr_d     = addr_q;
    a_d        = a_q;
    b_d        = b_q;
    fun_d      = fun_q;
    idx_d      = idx_q;
    tx_vld_d   = tx_vld_q;
    tx_data_d  = tx_data_q;
    cnt_d      = '0;
    rx_buf_d   = rx_buf_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    timed_out  = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.REQ_VLD) begin
          typ_d     = bus.REQ_TYPE;
          addr_d    = bus.REQ_ADDR;
          a_d       = bus.REQ_DATA_A;
          b_d       = bus.REQ_DATA_B;
          fun_d     = bus.REQ_FUN;
          idx_d     = 2'd0;
          rx_buf_d  = '0;
          tx_vld_d  = 1'b1;
          tx_data_d = frame_byte(bus.REQ_TYPE, 2'd0, bus.REQ_ADDR,
                                 bus.REQ_DATA_A, bus.REQ_DATA_B, bus.REQ_FUN);
          state_d   = SEND;
        end
      end
      SEND: begin
        if (tx_vld_q && !bus.TX_BUSY) begin
          if (idx_q == last_idx(typ_q)) begin
            tx_vld_d = 1'b0;
            case (typ_q)
              typ_wr:  state_d = DONE;
              typ_rd:  state_d = WAIT_RSP2;
              default: state_d = WAIT_RSP1;
            endcase
          end else begin
            idx_d     = idx_q + 2'd1;
            tx_data_d = frame_byte(typ_q, idx_q + 2'd1, addr_q, a_q, b_q, fun_q);
          end
        end
      end
      WAIT_RSP1: begin
        if (bus.RX_D_VLD) begin
          rx_buf_d[data_width-1:0] = bus.RX_P_DATA;
          state_d = WAIT_RSP2;
        end else if (cnt_q == cnt_last) begin
          timed_out = 1'b1;
          state_d   = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WAIT_RSP2: begin
        if (bus.RX_D_VLD) begin
          if (typ_q == typ_rd) rx_buf_d = {{data_width{1'b0}}, bus.RX_P_DATA};
          else rx_buf_d[2*data_width-1:data_width] = bus.RX_P_DATA;
          state_d = DONE;
        end else if (cnt_q == cnt_last) begin
          timed_out = 1'b1;
          state_d   = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // The visible response only changes when a new result is published.
    if (state_d == DONE) begin
      rsp_data_d = rx_buf_d;
      rsp_err_d  = timed_out;
    end
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= IDLE;
      typ_q      <= '0;
      addr_q     <= '0;
      a_q        <= '0;
      b_q        <= '0;
      fun_q      <= '0;
      idx_q      <= '0;
      tx_vld_q   <= 1'b0;
      tx_data_q  <= '0;
      cnt_q      <= '0;
      rx_buf_q   <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      typ_q      <= typ_d;
      addr_q     <= addr_d;
      a_q        <= a_d;
      b_q        <= b_d;
      fun_q      <= fun_d;
      idx_q      <= idx_d;
      tx_vld_q   <= tx_vld_d;
      tx_data_q  <= tx_data_d;
      cnt_q      <= cnt_d;
      rx_buf_q   <= rx_buf_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  assign bus.REQ_RDY   = (state_q == IDLE);
  assign bus.TX_D_VLD  = tx_vld_q;
  assign bus.TX_P_DATA = tx_data_q;
  assign bus.RSP_VLD   = (state_q == DONE);
  assign bus.RSP_DATA  = rsp_data_q;
  assign bus.RSP_ERR   = rsp_err_q;
  assign dbg_state     = state_q;

endmodule
